mips_writeback_unit: RTL

//  Write-side initiator for the 32x32 MIPS register file: takes retired results from MEM stage,

---
 rtl/mips_writeback_unit.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_writeback_unit.sv
// -----------------------------------------------------------------------------
// mips_writeback_unit
//   Write-side initiator for the 32x32 MIPS register file. Retired MEM-stage
//   results are decoded into a destination register (rt, rd or $31 for jal),
//   a byte-lane mask (lb / lh / full word) and write data (jal link = pc+4).
//   They are then buffered in a small FIFO and issued one register write per
//   cycle over a valid/ready port. A pending-destination scoreboard (busy)
//   lets decode stall on RAW hazards.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, adds a combinational search port that returns the newest
//   queued full-word write to a given register. When undefined, the bypass
//   ports and the search logic are absent.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        retire request handshake (in_ready = !full)
//   in_opcode, in_rt_rd        opcode and rt/rd destination select
//   in_rt, in_rd               register fields
//   in_data, in_pc             result/load data, PC of retiring instruction
//   wr_valid / wr_ready        register-file write handshake
//   wr_addr, wr_data, wr_mask  head-of-queue write (all zero when empty)
//   busy                       bit n set while a queued entry targets reg n
//   q_count                    number of queued entries (0..DEPTH)
//   byp_addr/byp_hit/byp_data  bypass search (WB_BYPASS_EN only)
// -----------------------------------------------------------------------------
module mips_writeback_unit #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [5:0]              in_opcode,
  input  logic                    in_rt_rd,
  input  logic [4:0]              in_rt,
  input  logic [4:0]              in_rd,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [31:0]             in_pc,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [4:0]              wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [3:0]              wr_mask,
  output logic [31:0]             busy,
  output logic [$clog2(DEPTH):0]  q_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]              byp_addr,
  output logic                    byp_hit,
  output logic [DATA_W-1:0]       byp_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;

  // Queue storage and control state
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [4:0]        addr_q [DEPTH];
  logic [4:0]        addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [3:0]        mask_q [DEPTH];
  logic [3:0]        mask_d [DEPTH];

  // Decoded incoming request
  logic [4:0]        dec_addr_s;
  logic [DATA_W-1:0] dec_data_s;
  logic [3:0]        dec_mask_s;

  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  // Resolve destination, byte lanes and write data for the incoming request
  always_comb begin
    dec_addr_s = in_rt_rd ? in_rt : in_rd;
    dec_data_s = in_data;
    dec_mask_s = 4'b1111;
    case (in_opcode)
      OP_JAL: begin
        dec_addr_s = 5'd31;
        dec_data_s = DATA_W'(in_pc + 32'd4);
      end
      OP_LB: begin
        dec_addr_s = in_rt;
        dec_mask_s = 4'b0001;
        dec_data_s = {{(DATA_W-8){1'b0}}, in_data[7:0]};
      end
      OP_LH: begin
        dec_addr_s = in_rt;
        dec_mask_s = 4'b0011;
        dec_data_s = {{(DATA_W-16){1'b0}}, in_data[15:0]};
      end
      default: begin
        dec_addr_s = in_rt_rd ? in_rt : in_rd;
      end
    endcase
  end

  // in_ready depends on the stored count only, so there is no path from wr_ready.
  // Writes to $0 complete the handshake but are dropped instead of queued.
  assign empty_s  = (count_q == {CNT_W{1'b0}});
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push_s   = in_valid & in_ready & (dec_addr_s != 5'd0);
  assign pop_s    = wr_valid & wr_ready;

  // Next-state computation for pointers, count and entry storage
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;

    if (push_s) begin
      addr_d[wr_ptr_q] = dec_addr_s;
      data_d[wr_ptr_q] = dec_data_s;
      mask_d[wr_ptr_q] = dec_mask_s;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // A pop never hits the slot being pushed: push needs !full, pop needs !empty
    if (pop_s) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards any in-flight entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      vld_q    <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= {DATA_W{1'b0}};
        mask_q[i] <= 4'b0000;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
        mask_q[i] <= mask_d[i];
      end
    end
  end

  // Head-of-queue write port, forced to zero when nothing is queued
  always_comb begin
    wr_valid = !empty_s;
    if (!empty_s) begin
      wr_addr = addr_q[rd_ptr_q];
      wr_data = data_q[rd_ptr_q];
      wr_mask = mask_q[rd_ptr_q];
    end else begin
      wr_addr = 5'd0;
      wr_data = {DATA_W{1'b0}};
      wr_mask = 4'b0000;
    end
  end

  // Pending-destination scoreboard: OR of one-hot destinations of valid entries
  always_comb begin
    busy = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      busy[addr_q[i]] = busy[addr_q[i]] | vld_q[i];
    end
    busy[0] = 1'b0;
  end

  assign q_count = count_q;

`ifdef WB_BYPASS_EN
  logic              byp_found_s;
  logic [3:0]        byp_mask_s;
  logic [DATA_W-1:0] byp_val_s;
  logic [PTR_W-1:0]  byp_slot_s;

  // Walk oldest to newest so the last match seen is the newest one
  always_comb begin
    byp_found_s = 1'b0;
    byp_mask_s  = 4'b0000;
    byp_val_s   = {DATA_W{1'b0}};
    byp_slot_s  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      byp_slot_s = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[byp_slot_s] == byp_addr)) begin
        byp_found_s = 1'b1;
        byp_mask_s  = mask_q[byp_slot_s];
        byp_val_s   = data_q[byp_slot_s];
      end else begin
        byp_found_s = byp_found_s;
      end
    end
  end

  // A partial-mask newest match cannot supply a whole register value
  assign byp_hit  = byp_found_s & (byp_mask_s == 4'b1111) & (byp_addr != 5'd0);
  assign byp_data = byp_hit ? byp_val_s : {DATA_W{1'b0}};
`endif

endmodule
